// File: rtl/gray_ptr_arbiter.sv
// Source-domain controller for a gray-code pointer synchronizer: round-robin
// increment arbitration, capacity tracking against the consumer pointer, and a drain FSM.
module gray_ptr_arbiter #(
    parameter int NUMBER_OF_BITS = 4,
    parameter int NUM_REQ        = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUMBER_OF_BITS-1:0] rd_ptr_gray,
    input  logic                      flush,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      enable,
    output logic [NUMBER_OF_BITS-1:0] wr_ptr,
    output logic [NUMBER_OF_BITS-1:0] used,
    output logic                      full,
    output logic                      empty,
    output logic                      flush_done,
    output logic                      err
);

    localparam int LGW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUMBER_OF_BITS-1:0] CAPACITY   = {1'b1, {(NUMBER_OF_BITS-1){1'b0}}};
    localparam logic [LGW-1:0]            LAST_RESET = LGW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [LGW-1:0]              last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0]          grant_q, grant_d;
    logic                        enable_q, enable_d;
    logic [NUMBER_OF_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [NUMBER_OF_BITS-1:0]   used_q, used_d;
    logic                        full_q, full_d;
    logic                        empty_q, empty_d;
    logic                        flush_done_q, flush_done_d;
    logic                        err_q, err_d;

    logic [NUMBER_OF_BITS-1:0]   rd_bin;
    logic [NUMBER_OF_BITS-1:0]   raw_used;
    logic                        eligible;
    logic                        found;
    logic [LGW-1:0]              winner;
    logic [LGW-1:0]              idx_l;
    int unsigned                 idx;

    // Gray to binary: each bit is the XOR of all gray bits at or above it.
    always_comb begin
        rd_bin = '0;
        rd_bin[NUMBER_OF_BITS-1] = rd_ptr_gray[NUMBER_OF_BITS-1];
        for (int unsigned i = 1; i < NUMBER_OF_BITS; i++) begin
            rd_bin[NUMBER_OF_BITS-1-i] = rd_bin[NUMBER_OF_BITS-i] ^ rd_ptr_gray[NUMBER_OF_BITS-1-i];
        end
    end

    assign raw_used = wr_ptr_q - rd_bin;

    // A flush arriving in RUN blocks the grant on that same edge.
    assign eligible = (state_q == ST_RUN) && !flush && (raw_used < CAPACITY) && !err_q && (|req);

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        idx_l  = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx   = (32'(last_grant_q) + off) % NUM_REQ;
            idx_l = LGW'(idx);
            if (!found && req[idx_l]) begin
                found  = 1'b1;
                winner = idx_l;
            end
        end
    end

    always_comb begin
        grant_d      = '0;
        last_grant_d = last_grant_q;
        if (eligible && found) begin
            grant_d[winner] = 1'b1;
            last_grant_d    = winner;
        end
        enable_d = |grant_d;
        wr_ptr_d = wr_ptr_q + NUMBER_OF_BITS'(enable_d);
        used_d   = wr_ptr_d - rd_bin;
        full_d   = (used_d == CAPACITY);
        empty_d  = (used_d == '0);
        err_d    = err_q | (raw_used > CAPACITY);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (flush) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!flush)                state_d = ST_RUN;
                else if (raw_used == '0)   state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!flush) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        flush_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            last_grant_q <= LAST_RESET;
            grant_q      <= '0;
            enable_q     <= 1'b0;
            wr_ptr_q     <= '0;
            used_q       <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            flush_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            enable_q     <= enable_d;
            wr_ptr_q     <= wr_ptr_d;
            used_q       <= used_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            flush_done_q <= flush_done_d;
            err_q        <= err_d;
        end
    end

    assign grant      = grant_q;
    assign enable     = enable_q;
    assign wr_ptr     = wr_ptr_q;
    assign used       = used_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign flush_done = flush_done_q;
    assign err        = err_q;

endmodule
